mult_result_display: RTL and testbench



---
 rtl/mult_result_display_if.sv | 22 ++
 rtl/mult_result_display.sv | 120 ++++++++++++
 tb/tb_mult_result_display.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mult_result_display_if.sv
// Bundle of the multiplier-result input strobe and the three-digit seven-segment
// display outputs that feed the 3-to-1 segment multiplexor.
interface mult_result_display_if;
  logic [7:0] product;
  logic       product_valid;
  logic       busy;
  logic [6:0] seg_units;
  logic [6:0] seg_tens;
  logic [6:0] seg_hundreds;
  logic [2:0] sel;
  logic [2:0] an;

  modport master (
    output product, product_valid,
    input  busy, seg_units, seg_tens, seg_hundreds, sel, an
  );

  modport slave (
    input  product, product_valid,
    output busy, seg_units, seg_tens, seg_hundreds, sel, an
  );
endinterface

// File: rtl/mult_result_display.sv
// Captures an 8-bit product, converts it to BCD with a sequential double-dabble
// engine, and drives blanked seven-segment patterns plus a one-hot digit scan.
module mult_result_display #(
  parameter int REFRESH_DIV = 100000
) (
  input logic                  clk,
  input logic                  rst_n,
  mult_result_display_if.slave bus
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t      state_q, state_d;
  logic [7:0]  bin_q, bin_d;
  logic [11:0] bcd_q, bcd_d;
  logic [2:0]  iter_q, iter_d;
  logic [11:0] bcd_adj;
  logic [6:0]  seg_units_q, seg_tens_q, seg_hundreds_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]  sel_q;

  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] pat;
    case (digit)
      4'd0:    pat = 7'h40;
      4'd1:    pat = 7'h79;
      4'd2:    pat = 7'h24;
      4'd3:    pat = 7'h30;
      4'd4:    pat = 7'h19;
      4'd5:    pat = 7'h12;
      4'd6:    pat = 7'h02;
      4'd7:    pat = 7'h78;
      4'd8:    pat = 7'h00;
      4'd9:    pat = 7'h10;
      default: pat = 7'h7F;
    endcase
    return pat;
  endfunction

  // Add-3 correction is applied to every nibble before the shift of each iteration.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                  bcd_q[gi*4 +: 4] + 4'd3 : bcd_q[gi*4 +: 4];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    iter_d  = iter_q;
    case (state_q)
      IDLE: begin
        if (bus.product_valid) begin
          bin_d   = bus.product;
          bcd_d   = '0;
          iter_d  = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj[10:0], bin_q, 1'b0};
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'd7) state_d = COMMIT;
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      iter_q  <= iter_d;
    end
  end

  // Segment registers are the committed digit store; they change only on COMMIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_units_q    <= 7'h40;
      seg_tens_q     <= 7'h7F;
      seg_hundreds_q <= 7'h7F;
    end else if (state_q == COMMIT) begin
      seg_units_q    <= seg_encode(bcd_q[3:0]);
      seg_tens_q     <= (bcd_q[11:4] == 8'd0) ? 7'h7F : seg_encode(bcd_q[7:4]);
      seg_hundreds_q <= (bcd_q[11:8] == 4'd0) ? 7'h7F : seg_encode(bcd_q[11:8]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sel_q <= 3'b001;
    end else if (cnt_q == CW'(REFRESH_DIV - 1)) begin
      cnt_q <= '0;
      sel_q <= {sel_q[1:0], sel_q[2]};
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.busy         = (state_q != IDLE);
  assign bus.seg_units    = seg_units_q;
  assign bus.seg_tens     = seg_tens_q;
  assign bus.seg_hundreds = seg_hundreds_q;
  assign bus.sel          = sel_q;
  assign bus.an           = ~sel_q;

endmodule

// File: tb/tb_mult_result_display.sv
// Scoreboard bench for mult_result_display: expected digit patterns are queued
// when a strobe is accepted and compared once the conversion finishes.
module tb_mult_result_display;

  localparam int RDIV = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  typedef struct {
    logic [6:0] u;
    logic [6:0] t;
    logic [6:0] h;
  } exp_t;

  exp_t sb[$];

  mult_result_display_if bus ();

  mult_result_display #(.REFRESH_DIV(RDIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] enc(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic exp_t model(input int p);
    exp_t e;
    int h, t, u;
    h = p / 100;
    t = (p / 10) % 10;
    u = p % 10;
    e.u = enc(u);
    e.t = (h == 0 && t == 0) ? 7'h7F : enc(t);
    e.h = (h == 0) ? 7'h7F : enc(h);
    return e;
  endfunction

  // Drive a strobe; returns at the negedge right after the sampling edge.
  task automatic strobe(input int p, input bit push);
    @(negedge clk);
    bus.product       = 8'(p);
    bus.product_valid = 1'b1;
    if (push) sb.push_back(model(p));
    @(negedge clk);
    bus.product_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    tests_run++;
    if (bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL busy_timeout: busy=%b after %0d cycles, required 0", bus.busy, n);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests_run++;
    if ({bus.busy, bus.seg_units, bus.seg_tens, bus.seg_hundreds, bus.sel, bus.an} !==
        {1'b0, 7'h40, 7'h7F, 7'h7F, 3'b001, 3'b110}) begin
      tests_failed++;
      $display("FAIL reset_init: busy=%b u=%h t=%h h=%h sel=%b an=%b, required 0 40 7f 7f 001 110",
               bus.busy, bus.seg_units, bus.seg_tens, bus.seg_hundreds, bus.sel, bus.an);
    end
    rst_n = 1'b1;
    $display("[TB] reset released");
  endtask

  task automatic test_product(input int p);
    int n;
    exp_t e;
    strobe(p, 1'b1);
    wait_idle(n);
    tests_run++;
    if (n !== 9) begin
      tests_failed++;
      $display("FAIL busy_len_%0d: busy held %0d cycles, required 9", p, n);
    end
    tests_run++;
    if (sb.size() == 0) begin
      tests_failed++;
      $display("FAIL sb_empty_%0d: no expected entry, required 1", p);
    end else begin
      e = sb.pop_front();
      if ({bus.seg_units, bus.seg_tens, bus.seg_hundreds} !== {e.u, e.t, e.h}) begin
        tests_failed++;
        $display("FAIL product_%0d: u=%h t=%h h=%h, required u=%h t=%h h=%h",
                 p, bus.seg_units, bus.seg_tens, bus.seg_hundreds, e.u, e.t, e.h);
      end
    end
    $display("[TB] product %0d -> u=%h t=%h h=%h busy=%0d cycles",
             p, bus.seg_units, bus.seg_tens, bus.seg_hundreds, n);
  endtask

  task automatic test_dropped();
    int n;
    exp_t e;
    strobe(64, 1'b1);
    @(negedge clk);
    tests_run++;
    if (bus.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL drop_busy: busy=%b, required 1", bus.busy);
    end
    bus.product       = 8'd200;
    bus.product_valid = 1'b1;
    @(negedge clk);
    bus.product_valid = 1'b0;
    wait_idle(n);
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL drop_queued: busy=%b after idle, required 0", bus.busy);
    end
    tests_run++;
    if (sb.size() != 1) begin
      tests_failed++;
      $display("FAIL drop_sb: %0d expected entries, required 1", sb.size());
    end else begin
      e = sb.pop_front();
      if ({bus.seg_units, bus.seg_tens, bus.seg_hundreds} !== {e.u, e.t, e.h}) begin
        tests_failed++;
        $display("FAIL drop_value: u=%h t=%h h=%h, required u=%h t=%h h=%h",
                 bus.seg_units, bus.seg_tens, bus.seg_hundreds, e.u, e.t, e.h);
      end
    end
    $display("[TB] dropped strobe 200 during 64 -> u=%h t=%h h=%h",
             bus.seg_units, bus.seg_tens, bus.seg_hundreds);
  endtask

  task automatic test_reset_mid_shift();
    strobe(255, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.busy, bus.seg_units, bus.seg_tens, bus.seg_hundreds, bus.sel, bus.an} !==
        {1'b0, 7'h40, 7'h7F, 7'h7F, 3'b001, 3'b110}) begin
      tests_failed++;
      $display("FAIL reset_mid: busy=%b u=%h t=%h h=%h sel=%b an=%b, required 0 40 7f 7f 001 110",
               bus.busy, bus.seg_units, bus.seg_tens, bus.seg_hundreds, bus.sel, bus.an);
    end
    repeat (2) @(negedge clk);
    tests_run++;
    if ({bus.busy, bus.seg_units} !== {1'b0, 7'h40}) begin
      tests_failed++;
      $display("FAIL reset_hold: busy=%b u=%h, required 0 40", bus.busy, bus.seg_units);
    end
    $display("[TB] reset mid-shift -> busy=%b u=%h", bus.busy, bus.seg_units);
  endtask

  // Called while rst_n is low at a negedge; edge k is the k-th posedge after release.
  task automatic test_scan();
    logic [2:0] exp_sel;
    int bad = 0;
    rst_n = 1'b1;
    for (int k = 0; k <= 24; k++) begin
      if (k > 0) @(negedge clk);
      exp_sel = 3'b001 << ((k / RDIV) % 3);
      tests_run++;
      if (bus.sel !== exp_sel || bus.an !== ~exp_sel || !$onehot(bus.sel)) begin
        tests_failed++;
        bad++;
        $display("FAIL scan_k%0d: sel=%b an=%b, required sel=%b an=%b",
                 k, bus.sel, bus.an, exp_sel, ~exp_sel);
      end
    end
    $display("[TB] scan 24 cycles, %0d bad samples", bad);
  endtask

  initial begin
    bus.product       = '0;
    bus.product_valid = 1'b0;
    test_reset();
    test_product(255);
    test_product(7);
    test_product(105);
    test_product(0);
    test_dropped();
    test_reset_mid_shift();
    test_scan();
    test_product(99);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
